// File: rtl/step_pulse_gen.sv
// step_pulse_gen
//   Stepper-driver pulse generator, one instance per axis. A move is requested
//   with start. The generator latches the direction, the step count, the period
//   and the high width. It drives dir_out, waits DIR_SETUP cycles so the driver
//   sees a stable direction, and then emits num_steps pulses on step_out. Each
//   pulse is high for h_eff cycles and repeats every p_eff cycles. A move can be
//   aborted at any point. All outputs are registered.
//
// Ports
//   clock_in     in   system clock
//   reset_n      in   asynchronous active-low reset
//   start        in   request a move (sampled only while idle)
//   abort        in   terminate the move in progress
//   dir_in       in   direction for the move, latched on start
//   num_steps    in   number of pulses, latched on start
//   period       in   cycles per step, latched on start
//   high_cycles  in   step_out high cycles per step, latched on start
//   step_out     out  step pulse to driver
//   dir_out      out  direction to driver
//   busy         out  move in progress
//   done         out  one-cycle pulse on normal completion
//   steps_done   out  pulses completed in the current or last move
module step_pulse_gen #(
    parameter int CNT_W     = 28,
    parameter int STEPS_W   = 16,
    parameter int DIR_SETUP = 2
) (
    input  logic               clock_in,
    input  logic               reset_n,
    input  logic               start,
    input  logic               abort,
    input  logic               dir_in,
    input  logic [STEPS_W-1:0] num_steps,
    input  logic [CNT_W-1:0]   period,
    input  logic [CNT_W-1:0]   high_cycles,
    output logic               step_out,
    output logic               dir_out,
    output logic               busy,
    output logic               done,
    output logic [STEPS_W-1:0] steps_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    // Reload value for the setup phase. It is clamped so that DIR_SETUP=0
    // never produces a negative constant; that path skips SETUP anyway.
    localparam int              SETUP_LD_I = (DIR_SETUP > 0) ? DIR_SETUP - 1 : 0;
    localparam logic [CNT_W:0]  SETUP_LD   = (CNT_W+1)'(SETUP_LD_I);

    // h_eff = max(high_cycles, 1). The result is one bit wider than the inputs,
    // so the later arithmetic cannot wrap when high_cycles is all-ones.
    function automatic logic [CNT_W:0] eff_high(input logic [CNT_W-1:0] hc);
        logic [CNT_W:0] h;
        h = {1'b0, hc};
        if (h == '0)
            h = (CNT_W+1)'(1);
        return h;
    endfunction

    // Length of the low phase, p_eff - h_eff, with p_eff = max(period, h_eff+1).
    // When period does not exceed h_eff, p_eff is h_eff+1 and the low phase is
    // exactly one cycle.
    function automatic logic [CNT_W:0] eff_low(input logic [CNT_W-1:0] per,
                                               input logic [CNT_W:0]   h);
        logic [CNT_W:0] p;
        logic [CNT_W:0] l;
        p = {1'b0, per};
        if (p > h)
            l = p - h;
        else
            l = (CNT_W+1)'(1);
        return l;
    endfunction

    state_t             state;
    logic [CNT_W:0]     cnt;        // cycles left in the current phase, minus one
    logic [CNT_W:0]     h_len;      // latched h_eff
    logic [CNT_W:0]     l_len;      // latched low-phase length
    logic [STEPS_W-1:0] steps_tgt;  // latched num_steps

    logic [CNT_W:0]     h_new;
    logic [CNT_W:0]     l_new;
    logic [STEPS_W:0]   steps_next;

    assign h_new      = eff_high(high_cycles);
    assign l_new      = eff_low(period, h_new);
    assign steps_next = {1'b0, steps_done} + 1'b1;

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            cnt        <= '0;
            h_len      <= '0;
            l_len      <= '0;
            steps_tgt  <= '0;
            steps_done <= '0;
            step_out   <= 1'b0;
            dir_out    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state != IDLE && abort) begin
                // Abort: steps_done keeps only the pulses whose low phase finished.
                state    <= IDLE;
                step_out <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        // abort in IDLE blocks the latch, so abort wins over start.
                        if (start && !abort) begin
                            h_len      <= h_new;
                            l_len      <= l_new;
                            steps_tgt  <= num_steps;
                            dir_out    <= dir_in;
                            steps_done <= '0;
                            if (num_steps == '0) begin
                                done <= 1'b1;
                            end else begin
                                busy <= 1'b1;
                                if (DIR_SETUP > 0) begin
                                    state <= SETUP;
                                    cnt   <= SETUP_LD;
                                end else begin
                                    state    <= HIGH;
                                    step_out <= 1'b1;
                                    cnt      <= h_new - 1'b1;
                                end
                            end
                        end
                    end
                    SETUP: begin
                        if (cnt == '0) begin
                            state    <= HIGH;
                            step_out <= 1'b1;
                            cnt      <= h_len - 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    HIGH: begin
                        if (cnt == '0) begin
                            state    <= LOW;
                            step_out <= 1'b0;
                            cnt      <= l_len - 1'b1;
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    LOW: begin
                        if (cnt == '0) begin
                            steps_done <= steps_next[STEPS_W-1:0];
                            if (steps_next < {1'b0, steps_tgt}) begin
                                state    <= HIGH;
                                step_out <= 1'b1;
                                cnt      <= h_len - 1'b1;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end
                        end else begin
                            cnt <= cnt - 1'b1;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        step_out <= 1'b0;
                        busy     <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
